cpu_ctrl_fsm: RTL and testbench



---
 rtl/cpu_ctrl_fsm.sv | 264 ++++++++++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control unit for the ARM32 core: free-running fetch/decode/execute loop with
// condition evaluation and parametrised fetch/data-memory wait states.
module cpu_ctrl_fsm #(
    parameter int unsigned FETCH_WAIT = 1,
    parameter int unsigned MEM_WAIT   = 1,
    parameter int unsigned ALU_OP_W   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          opcode,
    input  logic [3:0]          cond,
    input  logic [3:0]          nzcv,
    output logic                waiting,
    output logic                halted,
    output logic                retire,
    output logic [1:0]          wb_sel,
    output logic                w_en,
    output logic                wr_lr,
    output logic                wr_base,
    output logic                sel_A,
    output logic                sel_B,
    output logic                sel_shift,
    output logic                en_A,
    output logic                en_B,
    output logic                en_C,
    output logic                en_S,
    output logic                en_status,
    output logic [ALU_OP_W-1:0] ALU_op,
    output logic                load_ir,
    output logic                load_pc,
    output logic [1:0]          sel_pc,
    output logic                load_addr,
    output logic                sel_addr,
    output logic                ram_w_en
);

    localparam logic [6:0] OpNop = 7'b0000000;
    localparam logic [6:0] OpHlt = 7'b0000001;

    localparam logic [ALU_OP_W-1:0] AluAdd = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] AluSub = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] AluAnd = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] AluOrr = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] AluXor = ALU_OP_W'(4);

    localparam logic [3:0] FetchLoad = (FETCH_WAIT == 0) ? 4'd0 : 4'(FETCH_WAIT - 1);
    localparam logic [3:0] MemLoad   = (MEM_WAIT == 0) ? 4'd0 : 4'(MEM_WAIT - 1);

    typedef enum logic [3:0] {
        S_FETCH, S_FWAIT, S_DECODE, S_COND, S_EXEC, S_ALU, S_WB,
        S_BR, S_MEM, S_MWAIT, S_LDWB, S_BASEWB, S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] op_q, op_d;
    logic       mem_done;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = cy;
            4'h3:    cond_pass = !cy;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = cy && !z;
            4'h9:    cond_pass = !cy || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // NOP and undefined encodings both fall out of S_COND as a plain retire.
    function automatic logic op_known(input logic [6:0] op);
        if (op == OpHlt)                 op_known = 1'b1;
        else if (!op[6])                 op_known = (op != OpNop) && (op[2:0] <= 3'd5);
        else if (op[6:4] == 3'b100)      op_known = 1'b1;
        else                             op_known = 1'b0;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
            op_q    <= 7'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        mem_done  = 1'b0;
        halted    = 1'b0;
        retire    = 1'b0;
        wb_sel    = 2'd0;
        w_en      = 1'b0;
        wr_lr     = 1'b0;
        wr_base   = 1'b0;
        sel_A     = 1'b0;
        sel_B     = 1'b0;
        sel_shift = 1'b0;
        en_A      = 1'b0;
        en_B      = 1'b0;
        en_C      = 1'b0;
        en_S      = 1'b0;
        en_status = 1'b0;
        ALU_op    = AluAdd;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        sel_pc    = 2'd0;
        load_addr = 1'b0;
        sel_addr  = 1'b0;
        ram_w_en  = 1'b0;

        // Outputs stay quiet while reset is held, even though the state already reads S_FETCH.
        if (rst_n) begin
            unique case (state_q)
                S_FETCH: begin
                    load_addr = 1'b1;
                    if (FETCH_WAIT == 0) begin
                        state_d = S_DECODE;
                    end else begin
                        cnt_d   = FetchLoad;
                        state_d = S_FWAIT;
                    end
                end
                S_FWAIT: begin
                    if (cnt_q == 4'd0) state_d = S_DECODE;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                S_DECODE: begin
                    load_ir = 1'b1;
                    load_pc = 1'b1;
                    state_d = S_COND;
                end
                S_COND: begin
                    op_d = opcode;
                    if (!cond_pass(cond, nzcv) || !op_known(opcode)) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else if (opcode == OpHlt) begin
                        state_d = S_HALT;
                    end else if (opcode[6:3] == 4'b1000 && !opcode[0]) begin
                        state_d = S_BR;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!op_q[6]) begin
                        en_A      = !op_q[3];
                        en_B      = (|op_q[5:4]) && ((op_q[5:4] != 2'b01) || op_q[3]);
                        en_S      = (|op_q[5:4]) && ((op_q[5:4] != 2'b01) || op_q[3]);
                        sel_shift = op_q[5];
                    end else if (op_q[3]) begin
                        en_A = 1'b1;
                    end else begin
                        en_B = 1'b1;
                    end
                    state_d = S_ALU;
                end
                S_ALU: begin
                    en_C = 1'b1;
                    if (!op_q[6]) begin
                        sel_A     = op_q[3];
                        sel_B     = (op_q[5:4] != 2'b01);
                        en_status = (op_q[2:0] == 3'b010);
                        case (op_q[2:0])
                            3'b001, 3'b010: ALU_op = AluSub;
                            3'b011:         ALU_op = AluAnd;
                            3'b100:         ALU_op = AluOrr;
                            3'b101:         ALU_op = AluXor;
                            default:        ALU_op = AluAdd;
                        endcase
                        state_d = S_WB;
                    end else if (op_q[3]) begin
                        state_d = S_MEM;
                    end else begin
                        sel_A   = 1'b1;
                        state_d = S_BR;
                    end
                end
                S_WB: begin
                    w_en    = (op_q[2:0] != 3'b010);
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_BR: begin
                    load_pc = 1'b1;
                    sel_pc  = op_q[0] ? 2'd2 : 2'd1;
                    w_en    = op_q[1];
                    wr_lr   = op_q[1];
                    wb_sel  = op_q[1] ? 2'd2 : 2'd0;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_MEM: begin
                    load_addr = 1'b1;
                    sel_addr  = 1'b1;
                    ram_w_en  = !op_q[0];
                    if (MEM_WAIT == 0) begin
                        mem_done = 1'b1;
                    end else begin
                        cnt_d   = MemLoad;
                        state_d = S_MWAIT;
                    end
                end
                S_MWAIT: begin
                    if (cnt_q == 4'd0) mem_done = 1'b1;
                    else               cnt_d    = cnt_q - 4'd1;
                end
                S_LDWB: begin
                    w_en   = 1'b1;
                    wb_sel = 2'd1;
                    if (op_q[1]) begin
                        state_d = S_BASEWB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_BASEWB: begin
                    w_en    = 1'b1;
                    wr_base = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase

            // A bare store has no writeback, so it retires in its last memory cycle.
            if (mem_done) begin
                if (op_q[0]) begin
                    state_d = S_LDWB;
                end else if (op_q[1]) begin
                    state_d = S_BASEWB;
                end else begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
        end

        waiting = !retire;
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: per-cycle comparison against an instruction-level
// model of the expected control-word sequence, plus hand-computed latency and count checks.
module tb_cpu_ctrl_fsm;

    localparam int FW = 2;
    localparam int MW = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'b0100000;
    logic [3:0] cond = 4'hE;
    logic [3:0] nzcv = 4'h0;

    logic       waiting, halted, retire, w_en, wr_lr, wr_base;
    logic [1:0] wb_sel, sel_pc;
    logic       sel_A, sel_B, sel_shift, en_A, en_B, en_C, en_S, en_status;
    logic [2:0] ALU_op;
    logic       load_ir, load_pc, load_addr, sel_addr, ram_w_en;

    always #5 clk = ~clk;

    cpu_ctrl_fsm #(.FETCH_WAIT(FW), .MEM_WAIT(MW), .ALU_OP_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .cond(cond), .nzcv(nzcv),
        .waiting(waiting), .halted(halted), .retire(retire), .wb_sel(wb_sel), .w_en(w_en),
        .wr_lr(wr_lr), .wr_base(wr_base), .sel_A(sel_A), .sel_B(sel_B), .sel_shift(sel_shift),
        .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_S(en_S), .en_status(en_status),
        .ALU_op(ALU_op), .load_ir(load_ir), .load_pc(load_pc), .sel_pc(sel_pc),
        .load_addr(load_addr), .sel_addr(sel_addr), .ram_w_en(ram_w_en)
    );

    typedef struct packed {
        logic       waiting, halted, retire;
        logic [1:0] wb_sel;
        logic       w_en, wr_lr, wr_base, sel_A, sel_B, sel_shift;
        logic       en_A, en_B, en_C, en_S, en_status;
        logic [2:0] alu_op;
        logic       load_ir, load_pc;
        logic [1:0] sel_pc;
        logic       load_addr, sel_addr, ram_w_en;
    } out_t;

    out_t act;
    assign act = {waiting, halted, retire, wb_sel, w_en, wr_lr, wr_base, sel_A, sel_B, sel_shift,
                  en_A, en_B, en_C, en_S, en_status, ALU_op, load_ir, load_pc, sel_pc,
                  load_addr, sel_addr, ram_w_en};

    out_t  exp_q[$];
    string tag_q[$];
    int    tests = 0;
    int    fails = 0;
    bit    chk_en = 1'b0;
    int    wen_cnt = 0, ram_cnt = 0, halt_cnt = 0, halt_fetch = 0, ret_cnt = 0;
    int    lat_cnt = 0, last_lat = 0;
    int unsigned alu_code [0:5] = '{0, 1, 1, 2, 3, 4};

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return c[0] ? !r : r;
    endfunction

    function automatic void push(input out_t e, input string nm, input string st);
        out_t x;
        x = e;
        x.waiting = !x.retire;
        exp_q.push_back(x);
        tag_q.push_back({nm, ":", st});
    endfunction

    // Expected control-word stream for one instruction, built from the instruction-class rules.
    task automatic model_instr(input logic [6:0] op, input logic [3:0] cnd, input logic [3:0] f,
                               input string nm);
        out_t e;
        logic hlt, dp, br, ls;
        e = '0; e.load_addr = 1'b1; push(e, nm, "fetch");
        for (int i = 0; i < FW; i++) begin e = '0; push(e, nm, "fwait"); end
        e = '0; e.load_ir = 1'b1; e.load_pc = 1'b1; push(e, nm, "decode");
        hlt = (op == 7'b0000001);
        dp  = !op[6] && (op != 7'b0) && (op[2:0] < 3'd6);
        br  = (op[6:3] == 4'b1000);
        ls  = (op[6:3] == 4'b1001);
        e = '0;
        if (!cond_holds(cnd, f) || !(hlt || dp || br || ls)) begin
            e.retire = 1'b1; push(e, nm, "cond_skip");
        end else begin
            push(e, nm, "cond");
            if (hlt) begin
                for (int i = 0; i < 100; i++) begin e = '0; e.halted = 1'b1; push(e, nm, "halt"); end
            end else if (dp) begin
                e = '0;
                e.en_A = !op[3];
                e.en_B = (op[5:4] != 2'b00) && ((op[5:4] != 2'b01) || op[3]);
                e.en_S = e.en_B;
                e.sel_shift = op[5];
                push(e, nm, "exec");
                e = '0; e.en_C = 1'b1; e.sel_A = op[3]; e.sel_B = (op[5:4] != 2'b01);
                e.alu_op = 3'(alu_code[op[2:0]]); e.en_status = (op[2:0] == 3'b010);
                push(e, nm, "alu");
                e = '0; e.retire = 1'b1; e.w_en = (op[2:0] != 3'b010); push(e, nm, "wb");
            end else if (br) begin
                if (op[0]) begin
                    e = '0; e.en_B = 1'b1; push(e, nm, "exec");
                    e = '0; e.en_C = 1'b1; e.sel_A = 1'b1; push(e, nm, "alu");
                end
                e = '0; e.load_pc = 1'b1; e.sel_pc = op[0] ? 2'd2 : 2'd1; e.retire = 1'b1;
                if (op[1]) begin e.w_en = 1'b1; e.wr_lr = 1'b1; e.wb_sel = 2'd2; end
                push(e, nm, "br");
            end else begin
                e = '0; e.en_A = 1'b1; push(e, nm, "exec");
                e = '0; e.en_C = 1'b1; push(e, nm, "alu");
                e = '0; e.load_addr = 1'b1; e.sel_addr = 1'b1; e.ram_w_en = !op[0];
                e.retire = (MW == 0) && !op[0] && !op[1];
                push(e, nm, "mem");
                for (int i = 0; i < MW; i++) begin
                    e = '0; e.retire = (i == MW - 1) && !op[0] && !op[1]; push(e, nm, "mwait");
                end
                if (op[0]) begin
                    e = '0; e.w_en = 1'b1; e.wb_sel = 2'd1; e.retire = !op[1]; push(e, nm, "ldwb");
                end
                if (op[1]) begin
                    e = '0; e.w_en = 1'b1; e.wr_base = 1'b1; e.retire = 1'b1;
                    push(e, nm, "basewb");
                end
            end
        end
    endtask

    task automatic observe();
        out_t  e;
        string t;
        if (act.w_en) wen_cnt++;
        if (act.ram_w_en) ram_cnt++;
        if (act.halted) halt_cnt++;
        if (act.halted && act.load_addr) halt_fetch++;
        if (act.retire) ret_cnt++;
        if (act.load_addr && !act.sel_addr) lat_cnt = 1;
        else lat_cnt++;
        if (act.retire) last_lat = lat_cnt;
        if (chk_en && rst_n && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL %s: control word got %h want %h", t, act, e);
            end
        end
    endtask

    task automatic chk(input string name, input int a, input int w);
        tests++;
        if (a != w) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, a, w);
        end
    endtask

    task automatic chk_vec(input string name, input out_t a, input out_t w);
        tests++;
        if (a !== w) begin
            fails++;
            $display("FAIL %s: control word got %h want %h", name, a, w);
        end
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout, %0d expected cycles left want 0", nm, exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    task automatic run(input logic [6:0] op, input logic [3:0] cnd, input logic [3:0] f,
                       input string nm);
        model_instr(op, cnd, f, nm);
        @(posedge clk); #1;
        opcode = op; cond = cnd; nzcv = f;
        wait_drain(nm);
    endtask

    initial begin
        out_t rst_vec;
        rst_vec = '0;
        rst_vec.waiting = 1'b1;
        fork
            forever begin @(negedge clk); observe(); end
        join_none

        // Reset, then abort an ADD in its ALU cycle.
        repeat (2) @(posedge clk);
        #1 chk_vec("reset_outputs", act, rst_vec);
        wen_cnt = 0;
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("abort_in_alu_en_C", int'(en_C), 1);
        rst_n = 1'b0;
        #1 chk_vec("reset_abort_outputs", act, rst_vec);
        repeat (2) @(posedge clk);
        chk("abort_no_w_en", wen_cnt, 0);

        // ADD R-type: first cycle after release must fetch.
        chk_en = 1'b1;
        model_instr(7'b0100000, 4'hE, 4'h0, "add");
        chk("model_add_len", exp_q.size(), 8);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_drain("add");
        chk("add_latency", last_lat, 8);

        run(7'b0010010, 4'hE, 4'b0100, "cmp");
        chk("cmp_latency", last_lat, 8);
        run(7'b1000100, 4'h1, 4'b0100, "bne_skip");
        chk("bne_skip_latency", last_lat, 5);
        run(7'b1000100, 4'h1, 4'b0000, "bne_taken");
        chk("bne_taken_latency", last_lat, 6);
        run(7'b1000010, 4'hE, 4'b0000, "bl");
        chk("bl_latency", last_lat, 6);
        run(7'b1000001, 4'hE, 4'b0000, "bx");
        chk("bx_latency", last_lat, 8);
        run(7'b1000011, 4'hA, 4'b1001, "blx_ge");

        run(7'b1001011, 4'hE, 4'b0000, "ldr_wb");
        chk("ldr_wb_latency", last_lat, 13);
        ram_cnt = 0;
        run(7'b1001000, 4'hE, 4'b0000, "str");
        chk("str_ram_w_en_cycles", ram_cnt, 1);
        chk("str_latency", last_lat, 11);
        run(7'b1001001, 4'hB, 4'b1000, "ldr_lt");
        run(7'b1001010, 4'h8, 4'b0010, "str_wb_hi");

        run(7'b0101001, 4'h9, 4'b0100, "sub_ls");
        run(7'b0110101, 4'hC, 4'b0000, "xor_gt");
        run(7'b0001100, 4'h4, 4'b1000, "orr_mi");
        run(7'b0011011, 4'h7, 4'b0000, "and_vc");
        run(7'b0100000, 4'hD, 4'b0001, "add_le");
        run(7'b0100000, 4'hF, 4'b0000, "add_never");
        chk("never_latency", last_lat, 5);
        run(7'b0000110, 4'hE, 4'b0000, "undef_dp");
        chk("undef_latency", last_lat, 5);
        run(7'b1010000, 4'hE, 4'b0000, "undef_cls");
        run(7'b0000000, 4'hE, 4'b0000, "nop");

        halt_cnt = 0; halt_fetch = 0; ret_cnt = 0;
        run(7'b0000001, 4'hE, 4'b0000, "hlt");
        chk("halt_cycles", halt_cnt, 100);
        chk("halt_fetches", halt_fetch, 0);
        chk("halt_retires", ret_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
